tb_cmd_dispatcher: RTL

- Sits between the testbench sequencer and up to N_HANDLERS command handlers, e.g. drivers and checkers.
- Takes one decoded command (opcode + argument) per valid pulse and either executes it internally (NOP, WAIT, END) or starts the selected handler.
- Waits for the handler's completion, with a timeout, then returns a single-cycle ack.
- The ack is what makes the sequencer fetch its next command line, so this block paces the whole test.

---
 rtl/tb_cmd_dispatcher.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/tb_cmd_dispatcher.sv
// Command dispatcher between the test sequencer and N_HANDLERS handlers.
// Built-in commands (NOP, WAIT, END) run locally; handler commands pulse a
// one-hot start and wait for that handler's done, bounded by a timeout.
// Every finished command produces a single-cycle cmd_ack that paces the
// sequencer. A command is latched in IDLE, decoded in the following cycle
// (DECODE), then runs in BUSY, WAIT or goes straight to ACK.
//
// Handshake: cmd_valid is a one-cycle pulse accepted only in IDLE; the
// sequencer must not send again until it has seen cmd_ack. hdl_start is a
// one-cycle one-hot pulse; hdl_done/hdl_err of the selected handler are
// sampled every BUSY cycle, including the start cycle itself.
module tb_cmd_dispatcher #(
    parameter int N_HANDLERS     = 4,
    parameter int OPCODE_W       = 8,
    parameter int ARG_W          = 32,
    parameter int TMO_W          = 16,
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cmd_valid,
    input  logic [OPCODE_W-1:0]   cmd_opcode,
    input  logic [ARG_W-1:0]      cmd_arg,
    output logic                  cmd_ack,
    output logic                  cmd_err,
    output logic [N_HANDLERS-1:0] hdl_start,
    output logic [ARG_W-1:0]      hdl_arg,
    input  logic [N_HANDLERS-1:0] hdl_done,
    input  logic [N_HANDLERS-1:0] hdl_err,
    output logic                  end_test,
    output logic [15:0]           cmd_count,
    output logic [15:0]           err_count
);

    localparam int SEL_W = (N_HANDLERS > 1) ? $clog2(N_HANDLERS) : 1;
    // One counter serves both the timeout and WAIT, so it must hold a full argument.
    localparam int CNT_W = (ARG_W > TMO_W) ? ARG_W : TMO_W;

    localparam logic [OPCODE_W-1:0] OP_NOP  = '0;
    localparam logic [OPCODE_W-1:0] OP_WAIT = OPCODE_W'('hFE);
    localparam logic [OPCODE_W-1:0] OP_END  = OPCODE_W'('hFF);
    localparam logic [CNT_W-1:0]    TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        BOOT   = 3'd0,
        IDLE   = 3'd1,
        DECODE = 3'd2,
        BUSY   = 3'd3,
        WAIT   = 3'd4,
        ACK    = 3'd5,
        DONE   = 3'd6
    } state_t;

    state_t              state, state_nx;
    logic [OPCODE_W-1:0] op_q;
    logic [ARG_W-1:0]    arg_q;
    logic [CNT_W-1:0]    cnt_q, cnt_nx;
    logic                err_q, err_nx;
    logic                end_q, end_nx;
    logic                counted_q, counted_nx;

    logic                  is_handler;
    logic [SEL_W-1:0]      sel;
    logic                  done_sel;
    logic                  err_sel;
    logic [N_HANDLERS-1:0] start_vec;

    assign is_handler = (op_q != OP_NOP) && (op_q <= OPCODE_W'(N_HANDLERS));
    assign sel        = SEL_W'(op_q - OPCODE_W'(1));
    assign done_sel   = hdl_done[sel];
    assign err_sel    = hdl_err[sel];
    assign start_vec  = N_HANDLERS'(1) << sel;

    // State register, command latch and statistics counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= BOOT;
            op_q      <= '0;
            arg_q     <= '0;
            cnt_q     <= '0;
            err_q     <= 1'b0;
            end_q     <= 1'b0;
            counted_q <= 1'b0;
            cmd_count <= '0;
            err_count <= '0;
        end else begin
            state     <= state_nx;
            cnt_q     <= cnt_nx;
            err_q     <= err_nx;
            end_q     <= end_nx;
            counted_q <= counted_nx;
            if (state == IDLE && cmd_valid) begin
                op_q  <= cmd_opcode;
                arg_q <= cmd_arg;
            end
            if (state == ACK) begin
                if (counted_q)
                    cmd_count <= cmd_count + 16'd1;
                if (err_q && err_count != 16'hFFFF)
                    err_count <= err_count + 16'd1;
            end
        end
    end

    // Next-state logic: decode, handler supervision with timeout, WAIT countdown.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt_q;
        err_nx     = err_q;
        end_nx     = end_q;
        counted_nx = counted_q;
        case (state)
            BOOT: begin
                // Boot ack kicks the sequencer; it is not a command.
                err_nx     = 1'b0;
                counted_nx = 1'b0;
                state_nx   = ACK;
            end
            IDLE: begin
                if (cmd_valid) begin
                    err_nx     = 1'b0;
                    counted_nx = 1'b1;
                    state_nx   = DECODE;
                end
            end
            DECODE: begin
                if (is_handler) begin
                    cnt_nx   = '0;
                    state_nx = BUSY;
                end else if (op_q == OP_WAIT) begin
                    if (arg_q == '0) begin
                        state_nx = ACK;
                    end else begin
                        cnt_nx   = CNT_W'(arg_q);
                        state_nx = WAIT;
                    end
                end else if (op_q == OP_END) begin
                    end_nx   = 1'b1;
                    state_nx = ACK;
                end else if (op_q == OP_NOP) begin
                    state_nx = ACK;
                end else begin
                    err_nx   = 1'b1;
                    state_nx = ACK;
                end
            end
            BUSY: begin
                // A done in the timeout cycle still wins.
                if (done_sel) begin
                    err_nx   = err_sel;
                    state_nx = ACK;
                end else if (cnt_q == TMO_LAST) begin
                    err_nx   = 1'b1;
                    state_nx = ACK;
                end else begin
                    cnt_nx = cnt_q + CNT_W'(1);
                end
            end
            WAIT: begin
                if (cnt_q == CNT_W'(1))
                    state_nx = ACK;
                else
                    cnt_nx = cnt_q - CNT_W'(1);
            end
            ACK: begin
                state_nx = end_q ? DONE : IDLE;
            end
            DONE: begin
                state_nx = DONE;
            end
            default: begin
                state_nx = BOOT;
            end
        endcase
    end

    // Outputs decode from registered state only, so all are 0 while in reset.
    assign cmd_ack   = (state == ACK);
    assign cmd_err   = (state == ACK) && err_q;
    assign hdl_start = (state == BUSY && cnt_q == '0) ? start_vec : '0;
    assign hdl_arg   = arg_q;
    assign end_test  = (state == DONE);

    // Report commands sent while a previous one is still in flight.
    always_ff @(posedge clk) begin
        if (rst_n && cmd_valid && state != IDLE)
            $warning("tb_cmd_dispatcher: cmd_valid outside IDLE ignored (opcode 0x%0h)", cmd_opcode);
    end

endmodule
